// File: rtl/rotozoom_ctrl.sv
// Per-frame rotation/zoom parameter generator for a rotozoom coordinate engine.
// On each vsync rise: advance angle/zoom, look up sin/cos, shift-add multiply, publish du/dv.
module rotozoom_ctrl #(
    parameter logic [7:0] ZOOM_MIN = 8'd16,
    parameter logic [7:0] ZOOM_MAX = 8'd240
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               enable,
    input  logic [7:0]         angle_speed,
    input  logic [7:0]         zoom_speed,
    output logic signed [15:0] du,
    output logic signed [15:0] dv,
    output logic               params_valid,
    output logic               busy
);

    typedef enum logic [2:0] {WAIT_VS, ADVANCE, LOOKUP, MUL, COMMIT} state_t;

    // First quadrant of round(127*sin(2*pi*a/256)), a = 0..63
    localparam logic [6:0] QTAB [64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
    };

    // Quadrant folding; the peak (index 64) is not in the table, so it is special-cased
    function automatic logic signed [7:0] sine(input logic [7:0] a);
        logic [5:0] idx;
        logic [6:0] mag;
        idx  = a[6] ? 6'(7'd64 - {1'b0, a[5:0]}) : a[5:0];
        mag  = (a[6] && a[5:0] == 6'd0) ? 7'd127 : QTAB[idx];
        sine = a[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    state_t             state;
    logic [7:0]         angle;
    logic [7:0]         zoom;
    logic               zdir;
    logic               vsync_q;
    logic signed [15:0] mc_c;
    logic signed [15:0] mc_s;
    logic signed [15:0] acc_c;
    logic signed [15:0] acc_s;
    logic [7:0]         mplier;
    logic [2:0]         bit_cnt;

    logic               frame_start;
    logic [8:0]         up_sum;
    logic signed [9:0]  dn_diff;
    logic [7:0]         zoom_next;
    logic               zdir_next;
    logic signed [7:0]  s_val;
    logic signed [7:0]  c_val;
    logic signed [15:0] sum_c;
    logic signed [15:0] sum_s;

    always_comb begin
        frame_start = vsync && !vsync_q;
        up_sum      = {1'b0, zoom} + {1'b0, zoom_speed};
        dn_diff     = $signed({2'b00, zoom}) - $signed({2'b00, zoom_speed});
        zoom_next   = zoom;
        zdir_next   = zdir;
        if (zdir) begin
            if (up_sum >= {1'b0, ZOOM_MAX}) begin
                zoom_next = ZOOM_MAX;
                zdir_next = 1'b0;
            end else begin
                zoom_next = up_sum[7:0];
            end
        end else begin
            if (dn_diff <= $signed({2'b00, ZOOM_MIN})) begin
                zoom_next = ZOOM_MIN;
                zdir_next = 1'b1;
            end else begin
                zoom_next = dn_diff[7:0];
            end
        end
        s_val = sine(angle);
        c_val = sine(angle + 8'd64);
        sum_c = acc_c + (mplier[0] ? mc_c : 16'sd0);
        sum_s = acc_s + (mplier[0] ? mc_s : 16'sd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_VS;
            angle        <= 8'd0;
            zoom         <= ZOOM_MIN;
            zdir         <= 1'b1;
            vsync_q      <= 1'b1;
            du           <= 16'sd0;
            dv           <= 16'sd0;
            params_valid <= 1'b0;
            busy         <= 1'b0;
            mc_c         <= 16'sd0;
            mc_s         <= 16'sd0;
            acc_c        <= 16'sd0;
            acc_s        <= 16'sd0;
            mplier       <= 8'd0;
            bit_cnt      <= 3'd0;
        end else begin
            vsync_q      <= vsync;
            params_valid <= 1'b0;
            case (state)
                WAIT_VS: begin
                    if (frame_start) begin
                        state <= ADVANCE;
                        busy  <= 1'b1;
                    end
                end
                ADVANCE: begin
                    if (enable) begin
                        angle <= angle + angle_speed;
                        zoom  <= zoom_next;
                        zdir  <= zdir_next;
                    end
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    mc_c    <= {{8{c_val[7]}}, c_val};
                    mc_s    <= {{8{s_val[7]}}, s_val};
                    acc_c   <= 16'sd0;
                    acc_s   <= 16'sd0;
                    mplier  <= zoom;
                    bit_cnt <= 3'd0;
                    state   <= MUL;
                end
                MUL: begin
                    // One zoom bit per cycle, LSB first; the final partial sum goes straight to the outputs
                    acc_c   <= sum_c;
                    acc_s   <= sum_s;
                    mc_c    <= mc_c <<< 1;
                    mc_s    <= mc_s <<< 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        du           <= sum_c;
                        dv           <= sum_s;
                        params_valid <= 1'b1;
                        state        <= COMMIT;
                    end
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= WAIT_VS;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= WAIT_VS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotozoom_ctrl.sv
// Directed self-checking bench for rotozoom_ctrl: table of multi-frame vectors
// plus hand-written sequences for timing, mid-frame reset and vsync-at-reset.
module tb_rotozoom_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               vsync;
    logic               enable;
    logic [7:0]         angle_speed;
    logic [7:0]         zoom_speed;
    logic signed [15:0] du;
    logic signed [15:0] dv;
    logic               params_valid;
    logic               busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    rotozoom_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .enable       (enable),
        .angle_speed  (angle_speed),
        .zoom_speed   (zoom_speed),
        .du           (du),
        .dv           (dv),
        .params_valid (params_valid),
        .busy         (busy)
    );

    typedef struct {
        string       name;
        logic        en;
        logic [7:0]  aspd;
        logic [7:0]  zspd;
        int          frames;
        logic [15:0] exp_du;
        logic [15:0] exp_dv;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [7:0] aspd, input logic [7:0] zspd);
        enable      = en;
        angle_speed = aspd;
        zoom_speed  = zspd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Raise vsync, wait (bounded) for the params_valid pulse, then drop vsync
    task automatic run_frame(input string name);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (params_valid) seen = 1'b1;
        end
        check_output({name, " pv_seen"}, {15'd0, seen}, 16'd1);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic add_vec(input string name, input logic en, input logic [7:0] aspd,
                           input logic [7:0] zspd, input int frames,
                           input logic [15:0] edu, input logic [15:0] edv);
        vec_t v;
        v.name = name; v.en = en; v.aspd = aspd; v.zspd = zspd;
        v.frames = frames; v.exp_du = edu; v.exp_dv = edv;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pv_cnt;
        int busy_cnt;

        rst = 1'b1;
        vsync = 1'b0;
        apply_stimulus(1'b1, 8'd0, 8'd0);

        add_vec("ang0",          1'b1, 8'd0,   8'd0,   1,  16'd2032,  16'd0);
        add_vec("ang64_f1",      1'b1, 8'd64,  8'd0,   1,  16'd0,     16'd2032);
        add_vec("ang64_f2",      1'b1, 8'd64,  8'd0,   2,  16'hF810,  16'd0);
        add_vec("ang64_f4",      1'b1, 8'd64,  8'd0,   4,  16'd2032,  16'd0);
        add_vec("ang32",         1'b1, 8'd32,  8'd0,   1,  16'd1440,  16'd1440);
        add_vec("ang160",        1'b1, 8'd160, 8'd0,   1,  16'hFA60,  16'hFA60);
        add_vec("ang200",        1'b1, 8'd200, 8'd0,   1,  16'd400,   16'hF830);
        add_vec("ang3_z7",       1'b1, 8'd3,   8'd7,   1,  16'd2921,  16'd207);
        add_vec("ang192_zclamp", 1'b1, 8'd192, 8'd224, 1,  16'd0,     16'h88F0);
        add_vec("z15_f14",       1'b1, 8'd0,   8'd15,  14, 16'd28702, 16'd0);
        add_vec("z15_f15",       1'b1, 8'd0,   8'd15,  15, 16'd30480, 16'd0);
        add_vec("z15_f16",       1'b1, 8'd0,   8'd15,  16, 16'd28575, 16'd0);
        add_vec("z100_f5",       1'b1, 8'd0,   8'd100, 5,  16'd5080,  16'd0);
        add_vec("z100_f6",       1'b1, 8'd0,   8'd100, 6,  16'd2032,  16'd0);
        add_vec("z112_f3",       1'b1, 8'd0,   8'd112, 3,  16'd16256, 16'd0);
        add_vec("z112_f5",       1'b1, 8'd0,   8'd112, 5,  16'd16256, 16'd0);
        add_vec("hold_f1",       1'b0, 8'd37,  8'd9,   1,  16'd2032,  16'd0);
        add_vec("hold_f3",       1'b0, 8'd37,  8'd9,   3,  16'd2032,  16'd0);

        // Reset state
        do_reset();
        check_output("reset du", du, 16'd0);
        check_output("reset dv", dv, 16'd0);
        check_output("reset busy", {15'd0, busy}, 16'd0);
        check_output("reset pv", {15'd0, params_valid}, 16'd0);

        // Table-driven vectors, each from a fresh reset
        foreach (vecs[i]) begin
            do_reset();
            apply_stimulus(vecs[i].en, vecs[i].aspd, vecs[i].zspd);
            for (int f = 0; f < vecs[i].frames; f++) run_frame(vecs[i].name);
            check_output({vecs[i].name, " du"}, du, vecs[i].exp_du);
            check_output({vecs[i].name, " dv"}, dv, vecs[i].exp_dv);
        end

        // Cycle timing of busy/params_valid; vsync drops early and re-rises mid-frame
        do_reset();
        apply_stimulus(1'b1, 8'd0, 8'd0);
        @(negedge clk);
        vsync = 1'b1;
        check_output("seqA busy c0", {15'd0, busy}, 16'd0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check_output($sformatf("seqA busy c%0d", k), {15'd0, busy},
                         {15'd0, (k >= 1 && k <= 11)});
            check_output($sformatf("seqA pv c%0d", k), {15'd0, params_valid},
                         {15'd0, (k == 11)});
            if (k == 10) check_output("seqA du before commit", du, 16'd0);
            if (k == 11) begin
                check_output("seqA du commit", du, 16'd2032);
                check_output("seqA dv commit", dv, 16'd0);
            end
            if (k == 3) vsync = 1'b0;
            if (k == 5) vsync = 1'b1;
        end
        vsync = 1'b0;

        // Reset asserted in cycle 5 of a frame aborts it
        do_reset();
        apply_stimulus(1'b1, 8'd32, 8'd0);
        run_frame("seqB first");
        check_output("seqB first du", du, 16'd1440);
        @(negedge clk);
        vsync = 1'b1;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("seqB abort busy", {15'd0, busy}, 16'd0);
        check_output("seqB abort pv", {15'd0, params_valid}, 16'd0);
        check_output("seqB abort du", du, 16'd0);
        check_output("seqB abort dv", dv, 16'd0);
        rst = 1'b0;
        vsync = 1'b0;
        pv_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (params_valid) pv_cnt++;
        end
        check_output("seqB no pv after abort", 16'(pv_cnt), 16'd0);
        run_frame("seqB after");
        check_output("seqB after du", du, 16'd1440);
        check_output("seqB after dv", dv, 16'd1440);

        // vsync held high across reset release is not a frame start
        @(negedge clk);
        rst = 1'b1;
        vsync = 1'b1;
        apply_stimulus(1'b1, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pv_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (params_valid) pv_cnt++;
            if (busy) busy_cnt++;
        end
        check_output("seqC held pv", 16'(pv_cnt), 16'd0);
        check_output("seqC held busy", 16'(busy_cnt), 16'd0);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        pv_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (params_valid) pv_cnt++;
        end
        check_output("seqC one pv", 16'(pv_cnt), 16'd1);
        check_output("seqC du", du, 16'd2032);
        vsync = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/rotozoom_ctrl.md
ROTOZOOM_CTRL -- requirements
Module: rotozoom_ctrl

Interface
REQ-001 Parameter ZOOM_MIN, default 16: lower zoom bound, unsigned 8-bit; SHALL satisfy ZOOM_MIN < ZOOM_MAX.
REQ-002 Parameter ZOOM_MAX, default 240: upper zoom bound, unsigned 8-bit.
REQ-003 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 vsync  input  1: active-high vertical sync from the VGA timing block.
REQ-006 enable  input  1: 1 = animate angle/zoom each frame; 0 = freeze them.
REQ-007 angle_speed  input  8: angle increment per frame, unsigned, modulo 256.
REQ-008 zoom_speed  input  8: zoom increment/decrement per frame, unsigned.
REQ-009 du  output  16: signed per-pixel X step (per-line Y step) for the coordinate generator.
REQ-010 dv  output  16: signed per-pixel Y step; per-line X step is -dv.
REQ-011 params_valid  output  1: one-cycle pulse in the cycle du/dv take new values.
REQ-012 busy  output  1: high while the FSM is outside WAIT_VS.

Function
REQ-013 State: angle (8-bit unsigned), zoom (8-bit unsigned), zdir (1 = increasing), vsync_q (registered vsync).
REQ-014 Frame start SHALL be vsync=1 with vsync_q=0, sampled in WAIT_VS (call this cycle 0).
REQ-015 FSM states: WAIT_VS, ADVANCE, LOOKUP, MUL, COMMIT; WAIT_VS->ADVANCE on frame start, otherwise hold.
REQ-016 ADVANCE (cycle 1): if enable, angle <= angle + angle_speed mod 256, zoom updated per REQ-017/018; if !enable, angle/zoom/zdir hold.
REQ-017 Zoom up (zdir=1): 9-bit sum s = zoom + zoom_speed; s >= ZOOM_MAX -> zoom <= ZOOM_MAX, zdir <= 0; else zoom <= s.
REQ-018 Zoom down (zdir=0): s = zoom - zoom_speed (signed 10-bit); s <= ZOOM_MIN -> zoom <= ZOOM_MIN, zdir <= 1; else zoom <= s.
REQ-019 LOOKUP (cycle 2): read S = sin(angle), C = cos(angle) = sin(angle+64 mod 256) from internal table.
REQ-020 Table: S(a) = round(127*sin(2*pi*a/256)), signed 8-bit, range -127..127; SHALL be a 64-entry quarter-wave ROM with symmetry folding.
REQ-021 MUL (cycles 3..10, exactly 8 cycles): sequential shift-add computing C*zoom and S*zoom in parallel, one multiplier bit per cycle; no combinational multiplier.
REQ-022 Products SHALL be exact signed 16-bit (|result| <= 32385, no saturation).
REQ-023 COMMIT (cycle 11): du <= C*zoom, dv <= S*zoom, params_valid = 1 for this cycle only; next state WAIT_VS.
REQ-024 du/dv SHALL change only in COMMIT or reset.
REQ-025 vsync_q SHALL update every cycle; frame starts occurring outside WAIT_VS SHALL be ignored, not queued.
REQ-026 COMMIT SHALL occur even if vsync falls before cycle 11.
REQ-027 busy SHALL be 1 in ADVANCE, LOOKUP, MUL, COMMIT; 0 in WAIT_VS.

Reset
REQ-028 On rst=1: state WAIT_VS, angle=0, zoom=ZOOM_MIN, zdir=1, du=0, dv=0, params_valid=0, busy=0, multiplier registers cleared.
REQ-029 vsync_q SHALL reset to 1, so vsync high at reset release is not a frame start.
REQ-030 rst SHALL dominate all other inputs in any state, including mid-MUL; no params_valid is emitted for an aborted frame.

Verification
REQ-031 Reset, enable=1, angle_speed=0, zoom_speed=0, vsync rise -> busy high cycles 1..11, params_valid only at cycle 11, du=2032 (16'h07F0), dv=0.
REQ-032 Reset, angle_speed=64, zoom_speed=0: frame 1 -> du=0, dv=2032; frame 2 -> du=-2032 (16'hF810), dv=0; frame 4 -> du=2032, dv=0.
REQ-033 Reset, angle_speed=0, zoom_speed=15: frame 14 -> du=127*226=28702; frame 15 -> zoom clamped 240, du=30480; frame 16 -> zoom 225, du=28575.
REQ-034 rst asserted at cycle 5 of a frame -> no params_valid, du=dv=0, busy=0 next cycle; next vsync rise processes normally from angle=0.
REQ-035 vsync held high through reset release -> no computation; after vsync falls and rises -> one params_valid.
REQ-036 enable=0, angle_speed=37, zoom_speed=9, three frames -> params_valid pulses each frame, du/dv identical every frame.
